// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Shared definitions for the UART control path: the scheduler FSM state
// encoding and width helpers used to size requester ids and counters.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

    // Scheduler FSM states, one frame per pass through the loop
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_GAP        = 3'd4
    } sched_state_t;

    // Width of a requester index; never below one bit
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach max(a,b)-1 without wrapping
    function automatic int cnt_w(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Searches the request vector starting one
// position above the last winner (ptr) and wrapping, so the last winner has
// the lowest priority. Shared by the TX scheduler and the RX return path.
// Ports:
//   req      in  N     request vector
//   ptr      in  IDW   index of the previous winner
//   grant    out N     one-hot grant (all zero when no request)
//   grant_id out IDW   index of the granted requester
//   valid    out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           valid
);

    int   idx_s;
    logic found_s;

    // Rotating priority search: first set bit above ptr, wrapping around
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found_s  = 1'b0;
        idx_s    = 0;
        for (int i = 1; i <= N; i++) begin
            idx_s = (int'(ptr) + i) % N;
            if (!found_s && req[idx_s]) begin
                found_s        = 1'b1;
                grant[idx_s]   = 1'b1;
                grant_id       = IDW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
        valid = found_s;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between NUM_REQ byte requesters. One frame at a
// time: a one-cycle tx_dv pulse, wait for tx_active to rise, wait for it to
// fall, then hold off for GAP_CLKS clocks before the next launch. Requesters
// get an ack pulse when their byte is captured and a done pulse when their
// frame has left the wire. A start watchdog raises a sticky error if the
// transmitter never goes active after a launch.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   req [NUM_REQ]     level request per requester, held until req_ack
//   req_data [8*N]    byte of requester i at [8*i+:8]
//   req_ack [NUM_REQ] pulse: byte captured
//   req_done[NUM_REQ] pulse: frame including stop bit finished
//   tx_dv, tx_byte    launch strobe and byte to the transmitter
//   tx_active         transmitter busy flag
//   busy              scheduler not idle
//   cur_id            requester currently being served
//   err_timeout/err_id sticky start-timeout flag and offending requester
//   err_clr           synchronous clear of the error registers
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ       = 4,
    parameter int  GAP_CLKS      = 16,
    parameter int  START_TIMEOUT = 8,
    localparam int ID_W          = id_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 tx_dv,
    output logic [7:0]           tx_byte,
    input  logic                 tx_active,
    output logic                 busy,
    output logic [ID_W-1:0]      cur_id,
    output logic                 err_timeout,
    output logic [ID_W-1:0]      err_id,
    input  logic                 err_clr
);

    localparam int CNT_W = cnt_w(GAP_CLKS, START_TIMEOUT);
    localparam logic [ID_W-1:0]  PTR_RST   = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CLKS - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    sched_state_t        state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [ID_W-1:0]     ptr_r, ptr_s;
    logic [ID_W-1:0]     cur_id_r, cur_id_s;
    logic [7:0]          tx_byte_r, tx_byte_s;
    logic                tx_dv_r, tx_dv_s;
    logic [NUM_REQ-1:0]  req_ack_r, req_ack_s;
    logic [NUM_REQ-1:0]  req_done_r, req_done_s;
    logic                busy_r, busy_s;
    logic                err_r, err_s;
    logic [ID_W-1:0]     err_id_r, err_id_s;

    logic [NUM_REQ-1:0]  grant_s;
    logic [ID_W-1:0]     grant_id_s;
    logic                grant_vld_s;

    logic                launch_s;
    logic                start_to_s;
    logic                frame_end_s;
    logic                gap_end_s;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req      (req),
        .ptr      (ptr_r),
        .grant    (grant_s),
        .grant_id (grant_id_s),
        .valid    (grant_vld_s)
    );

    // A frame still in flight (e.g. across our reset) blocks any new launch
    assign launch_s    = (state_r == ST_IDLE) && grant_vld_s && !tx_active;
    assign start_to_s  = (state_r == ST_WAIT_START) && !tx_active && (cnt_r == TO_LAST);
    assign frame_end_s = (state_r == ST_WAIT_DONE) && !tx_active;
    assign gap_end_s   = (state_r == ST_GAP) && (cnt_r == GAP_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_active) begin
                    state_s = ST_WAIT_DONE;
                end else if (start_to_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_WAIT_START;
                end
            end
            ST_WAIT_DONE: begin
                if (frame_end_s) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_WAIT_DONE;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; registered below so every output is a flop
    always_comb begin
        tx_dv_s    = launch_s;
        req_ack_s  = launch_s ? grant_s : '0;
        req_done_s = frame_end_s ? (ONE_HOT0 << cur_id_r) : '0;
        busy_s     = (state_s != ST_IDLE);
        tx_byte_s  = tx_byte_r;
        cur_id_s   = cur_id_r;
        ptr_s      = ptr_r;
        cnt_s      = '0;
        err_s      = err_r;
        err_id_s   = err_id_r;

        if (launch_s) begin
            tx_byte_s = req_data[8*int'(grant_id_s) +: 8];
            cur_id_s  = grant_id_s;
            ptr_s     = grant_id_s;
        end else begin
            tx_byte_s = tx_byte_r;
        end

        case (state_r)
            ST_WAIT_START: begin
                if (tx_active || start_to_s) begin
                    cnt_s = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    cnt_s = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_s = '0;
            end
        endcase

        // A timeout in the same cycle as a clear must survive
        if (start_to_s) begin
            err_s    = 1'b1;
            err_id_s = cur_id_r;
        end else if (err_clr) begin
            err_s    = 1'b0;
            err_id_s = '0;
        end else begin
            err_s    = err_r;
            err_id_s = err_id_r;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_dv_r    <= 1'b0;
            req_ack_r  <= '0;
            req_done_r <= '0;
            busy_r     <= 1'b0;
            tx_byte_r  <= 8'h00;
            cur_id_r   <= '0;
            ptr_r      <= PTR_RST;
            cnt_r      <= '0;
            err_r      <= 1'b0;
            err_id_r   <= '0;
        end else begin
            tx_dv_r    <= tx_dv_s;
            req_ack_r  <= req_ack_s;
            req_done_r <= req_done_s;
            busy_r     <= busy_s;
            tx_byte_r  <= tx_byte_s;
            cur_id_r   <= cur_id_s;
            ptr_r      <= ptr_s;
            cnt_r      <= cnt_s;
            err_r      <= err_s;
            err_id_r   <= err_id_s;
        end
    end

    assign tx_dv       = tx_dv_r;
    assign req_ack     = req_ack_r;
    assign req_done    = req_done_r;
    assign busy        = busy_r;
    assign tx_byte     = tx_byte_r;
    assign cur_id      = cur_id_r;
    assign err_timeout = err_r;
    assign err_id      = err_id_r;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler with a small behavioural transmitter
// (4 clocks per bit, start + 8 data LSB first + stop, one cleanup cycle).
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  req_done;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        busy;
    logic [1:0]  cur_id;
    logic        err_timeout;
    logic [1:0]  err_id;
    logic        err_clr;
    logic        tie_low = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .NUM_REQ       (4),
        .GAP_CLKS      (4),
        .START_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .req_done    (req_done),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_active   (tx_active),
        .busy        (busy),
        .cur_id      (cur_id),
        .err_timeout (err_timeout),
        .err_id      (err_id),
        .err_clr     (err_clr)
    );

    // Behavioural transmitter (no reset, like the real one)
    int         tm_state = 0;
    int         tm_cnt   = 0;
    int         tm_bit   = 0;
    logic [9:0] tm_frame = 10'h3FF;
    logic       tm_act   = 1'b0;
    logic       txd      = 1'b1;

    assign tx_active = tie_low ? 1'b0 : tm_act;

    always @(posedge clk) begin
        case (tm_state)
            0: begin
                if (tx_dv && !tie_low) begin
                    tm_frame <= {1'b1, tx_byte, 1'b0};
                    tm_state <= 1;
                    tm_cnt   <= 0;
                    tm_bit   <= 0;
                    tm_act   <= 1'b1;
                    txd      <= 1'b0;
                end
            end
            1: begin
                if (tm_cnt == 3) begin
                    tm_cnt <= 0;
                    if (tm_bit == 9) begin
                        tm_state <= 2;
                        tm_act   <= 1'b0;
                        txd      <= 1'b1;
                    end else begin
                        tm_bit <= tm_bit + 1;
                        txd    <= tm_frame[tm_bit+1];
                    end
                end else begin
                    tm_cnt <= tm_cnt + 1;
                end
            end
            default: tm_state <= 0;
        endcase
    end

    // Monitor: event counts, serve order, overlap and inter-frame idle time
    int         ack_cnt[4];
    int         done_cnt[4];
    int         dv_cnt;
    int         overlap;
    int         idle_run = 1000;
    int         min_gap;
    int         order[$];
    logic [7:0] bytes_q[$];
    logic [9:0] cap_bits;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_dv) begin
                dv_cnt++;
                order.push_back(int'(cur_id));
                bytes_q.push_back(tx_byte);
                if (tm_state != 0) overlap++;
                if (idle_run < min_gap) min_gap = idle_run;
            end
            for (int i = 0; i < 4; i++) begin
                if (req_ack[i])  ack_cnt[i]++;
                if (req_done[i]) done_cnt[i]++;
            end
        end
        if (tx_active) idle_run = 0;
        else           idle_run++;
        if (tm_state == 1 && tm_cnt == 2) cap_bits[tm_bit] = txd;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            ack_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
        dv_cnt   = 0;
        overlap  = 0;
        min_gap  = 1000;
        idle_run = 1000;
        order.delete();
        bytes_q.delete();
        cap_bits = 10'h000;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = 4'h0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic wait_ack(input int i, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (req_ack[i]) seen = 1'b1;
        end
        check($sformatf("ack%0d_seen", i), seen, 1);
    endtask

    task automatic wait_done(input int i, input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (req_done[i]) seen = 1'b1;
        end
        check($sformatf("done%0d_seen", i), seen, 1);
    endtask

    task automatic wait_idle(input int budget);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        check("idle_reached", seen, 1);
        @(posedge clk);
    endtask

    initial begin
        logic seen;
        int   early;

        rst_n    = 1'b0;
        req      = 4'h0;
        err_clr  = 1'b0;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        clear_stats();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     busy, 0);
        check("rst_tx_dv",    tx_dv, 0);
        check("rst_tx_byte",  tx_byte, 0);
        check("rst_cur_id",   cur_id, 0);
        check("rst_err",      {err_timeout, err_id}, 0);
        check("rst_ack_done", {req_ack, req_done}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 2, byte 0xA5
        req_data[23:16] = 8'hA5;
        @(posedge clk);
        #1 req = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        check("t1_tx_dv",   tx_dv, 1);
        check("t1_ack",     req_ack, 4'b0100);
        check("t1_tx_byte", tx_byte, 8'hA5);
        check("t1_cur_id",  cur_id, 2);
        check("t1_busy",    busy, 1);
        req = 4'h0;
        wait_done(2, 200);
        wait_idle(50);
        check("t1_dv_cnt",   dv_cnt, 1);
        check("t1_ack_cnt",  ack_cnt[2], 1);
        check("t1_done_cnt", done_cnt[2], 1);
        check("t1_txd_bits", cap_bits, 10'h34A);

        // Four persistent requesters: strict rotation 0,1,2,3,0
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'hF;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(posedge clk);
            if (dv_cnt >= 5) seen = 1'b1;
        end
        check("t2_five_frames", seen, 1);
        #1 req = 4'h0;
        wait_idle(200);
        check("t2_dv_cnt", dv_cnt, 5);
        if (order.size() == 5) begin
            check("t2_order0", order[0], 0);
            check("t2_order1", order[1], 1);
            check("t2_order2", order[2], 2);
            check("t2_order3", order[3], 3);
            check("t2_order4", order[4], 0);
            check("t2_byte2",  bytes_q[2], 8'h12);
            check("t2_byte4",  bytes_q[4], 8'h10);
        end else begin
            check("t2_order_size", order.size(), 5);
        end
        check("t2_overlap", overlap, 0);
        check("t2_min_gap_ge4", (min_gap >= 4), 1);
        check("t2_done0_cnt", done_cnt[0], 2);

        // Requester 1 withdraws just before it would win; 3 is served instead
        do_reset();
        req = 4'b0001;
        wait_ack(0, 10);
        req = 4'b1010;
        wait_done(0, 200);
        repeat (4) @(posedge clk);
        #1 req[1] = 1'b0;
        wait_ack(3, 20);
        check("t3_cur_id", cur_id, 3);
        req[3] = 1'b0;
        wait_idle(200);
        check("t3_ack1",   ack_cnt[1], 0);
        check("t3_done1",  done_cnt[1], 0);
        check("t3_done3",  done_cnt[3], 1);
        check("t3_dv_cnt", dv_cnt, 2);

        // Transmitter never goes active: start timeout
        do_reset();
        tie_low = 1'b1;
        req = 4'b0010;
        wait_ack(1, 10);
        req = 4'h0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("t4_err_early", err_timeout, 0);
        @(posedge clk);
        @(negedge clk);
        check("t4_err_set", err_timeout, 1);
        check("t4_err_id",  err_id, 1);
        check("t4_busy",    busy, 1);
        wait_idle(50);
        check("t4_no_done", done_cnt[1], 0);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("t4_err_clr",    err_timeout, 0);
        check("t4_err_id_clr", err_id, 0);
        req = 4'b0100;
        wait_ack(2, 10);
        req = 4'h0;
        repeat (8) @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("t4_set_beats_clr", err_timeout, 1);
        check("t4_err_id2",       err_id, 2);
        wait_idle(50);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        tie_low = 1'b0;

        // Reset in the middle of a frame (data bit 3)
        do_reset();
        req_data[7:0] = 8'h3C;
        req = 4'b0001;
        wait_ack(0, 10);
        req = 4'h0;
        repeat (18) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_busy",    busy, 0);
        check("t5_tx_dv",   tx_dv, 0);
        check("t5_tx_byte", tx_byte, 0);
        check("t5_cur_id",  cur_id, 0);
        check("t5_ack",     req_ack, 0);
        req = 4'b0010;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen  = 1'b0;
        early = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (tx_dv) early++;
            if (!tx_active) seen = 1'b1;
        end
        check("t5_active_fell", seen, 1);
        check("t5_no_early_launch", early, 0);
        wait_ack(1, 30);
        check("t5_cur_id_after", cur_id, 1);
        req = 4'h0;
        wait_done(1, 200);
        wait_idle(50);
        check("t5_lost_done0", done_cnt[0], 0);

        // Requester 0 re-requests on its done cycle while 1 waits: 1 goes first
        do_reset();
        req = 4'b0001;
        wait_ack(0, 10);
        req = 4'b0010;
        wait_done(0, 200);
        req[0] = 1'b1;
        wait_ack(1, 30);
        req[1] = 1'b0;
        wait_ack(0, 200);
        req[0] = 1'b0;
        wait_idle(200);
        check("t6_dv_cnt", dv_cnt, 3);
        if (order.size() == 3) begin
            check("t6_order1", order[1], 1);
            check("t6_order2", order[2], 0);
        end else begin
            check("t6_order_size", order.size(), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
